// File: rtl/ram_master.sv
// ram_master: clears a single-port synchronous RAM after reset, then serves
// single-word write and read requests with a fixed 2-cycle read latency.
module ram_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned MEM_DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        CLEAR    = 2'd0,
        IDLE     = 2'd1,
        RD_WAIT1 = 2'd2,
        RD_WAIT2 = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_next;
    logic                    rd_oor, rd_oor_next;
    logic                    mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_din_next;
    logic                    rsp_valid_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_next;
    logic                    rsp_err_next;
    logic                    req_oor_c;

    // Request address beyond the implemented words
    assign req_oor_c = (32'(req_addr) >= MEM_DEPTH);

    // Handshake and status decoded straight from state
    assign req_ready = (state == IDLE) && !clear_start;
    assign busy      = (state != IDLE);

    // State, clear counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            rd_oor    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= clr_cnt_next;
            rd_oor    <= rd_oor_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_din   <= mem_din_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
            rsp_err   <= rsp_err_next;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_next     = state;
        clr_cnt_next   = clr_cnt;
        rd_oor_next    = rd_oor;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr;
        mem_din_next   = mem_din;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata;
        rsp_err_next   = 1'b0;

        case (state)
            CLEAR: begin
                mem_we_next   = 1'b1;
                mem_addr_next = clr_cnt;
                mem_din_next  = '0;
                clr_cnt_next  = clr_cnt + ADDR_WIDTH'(1);
                if (32'(clr_cnt) == MEM_DEPTH - 1) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clear_start) begin
                    clr_cnt_next = '0;
                    state_next   = CLEAR;
                end else if (req_valid) begin
                    mem_addr_next = req_addr;
                    if (req_we) begin
                        mem_din_next = req_wdata;
                        mem_we_next  = !req_oor_c;
                        rsp_err_next = req_oor_c;
                    end else begin
                        rd_oor_next = req_oor_c;
                        state_next  = RD_WAIT1;
                    end
                end
            end
            RD_WAIT1: begin
                state_next = RD_WAIT2;
            end
            RD_WAIT2: begin
                rsp_valid_next = 1'b1;
                rsp_err_next   = rd_oor;
                rsp_rdata_next = rd_oor ? '0 : mem_dout;
                state_next     = IDLE;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: drives two ram_master instances (full-depth and 100-word)
// against behavioural RAMs; read data is scoreboarded against a memory model.
module tb_ram_master;

    localparam int DW      = 8;
    localparam int AW      = 7;
    localparam int DEPTH   = 128;
    localparam int DEPTH_B = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals (default parameters)
    logic          rst_n, clear_start, req_valid, req_we, req_ready;
    logic [AW-1:0] req_addr, mem_addr;
    logic [DW-1:0] req_wdata, rsp_rdata, mem_din, mem_dout;
    logic          rsp_valid, rsp_err, busy, mem_we;

    // Instance B signals (MEM_DEPTH = 100)
    logic          rst_n_b, clear_start_b, req_valid_b, req_we_b, req_ready_b;
    logic [AW-1:0] req_addr_b, mem_addr_b;
    logic [DW-1:0] req_wdata_b, rsp_rdata_b, mem_din_b, mem_dout_b;
    logic          rsp_valid_b, rsp_err_b, busy_b, mem_we_b;

    logic [DW-1:0] ram_a [DEPTH];
    logic [DW-1:0] ram_b [DEPTH];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    ram_master u_dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    ram_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .clear_start(clear_start_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .busy(busy_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_din(mem_din_b), .mem_dout(mem_dout_b)
    );

    // Behavioural single-port synchronous RAMs
    always @(posedge clk) begin
        if (mem_we) ram_a[mem_addr] <= mem_din;
        mem_dout <= ram_a[mem_addr];
        if (mem_we_b) ram_b[mem_addr_b] <= mem_din_b;
        mem_dout_b <= ram_b[mem_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response of instance A must match the oldest expectation
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rsp_valid) begin
            check("rsp_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(e));
            end
            check("rsp_err_a", 32'(rsp_err), 0);
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", 32'(req_ready), 1);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        wait_ready();
        @(negedge clk);
        check("wr_mem_we",   32'(mem_we),   1);
        check("wr_mem_addr", 32'(mem_addr), 32'(a));
        check("wr_mem_din",  32'(mem_din),  32'(d));
        model[a] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        wait_ready();
        exp_q.push_back(model[a]);
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_mem_we",   32'(mem_we),    0);
        check("rd_ready_w1", 32'(req_ready), 0);
        check("rd_early_w1", 32'(rsp_valid), 0);
        @(negedge clk);
        check("rd_ready_w2", 32'(req_ready), 0);
        check("rd_early_w2", 32'(rsp_valid), 0);
        @(negedge clk);
        check("rd_latency",  32'(rsp_valid), 1);
        check("rd_ready_back", 32'(req_ready), 1);
    endtask

    task automatic wait_clear();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (!(mem_we === 1'b1 && mem_addr === AW'(i) && mem_din === 8'h00)) bad++;
            if (i < DEPTH - 1 && busy !== 1'b1) bad++;
        end
        check("clear_seq",  32'(bad), 0);
        check("clear_busy", 32'(busy), 0);
        check("clear_ready", 32'(req_ready), 1);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic rd_b(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic ee);
        req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = a;
        #1 check("b_rd_ready", 32'(req_ready_b), 1);
        @(negedge clk);
        req_valid_b = 1'b0;
        check("b_rd_mem_we", 32'(mem_we_b), 0);
        @(negedge clk);
        check("b_rd_early", 32'(rsp_valid_b), 0);
        @(negedge clk);
        check("b_rd_valid", 32'(rsp_valid_b), 1);
        check("b_rd_err",   32'(rsp_err_b),   32'(ee));
        check("b_rd_data",  32'(rsp_rdata_b), 32'(ed));
    endtask

    initial begin
        time t0;
        int  bad;
        clear_start = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        clear_start_b = 1'b0; req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
        rst_n = 1'b1; rst_n_b = 1'b1;
        #2;
        rst_n = 1'b0; rst_n_b = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_busy",      32'(busy),      1);
        check("rst_ready",     32'(req_ready), 0);
        check("rst_mem_we",    32'(mem_we),    0);
        check("rst_mem_addr",  32'(mem_addr),  0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        rst_n = 1'b1;
        wait_clear();
        idle(1);
        check("idle_mem_we", 32'(mem_we), 0);

        // Write then immediate read of same address; untouched address reads 0
        wr(7, 8'hA5);
        rd(7);
        idle(1);
        check("rdata_hold",  32'(rsp_rdata), 'hA5);
        check("valid_pulse", 32'(rsp_valid), 0);
        rd(8);

        // Back-to-back writes then readback
        t0 = $time;
        wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44);
        check("b2b_cycles", 32'(($time - t0) / 10), 4);
        idle(1);
        for (int i = 0; i < 4; i++) rd(AW'(i));

        // clear_start during read wait states is ignored and not queued
        wr(5, 8'h5A);
        idle(1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5;
        wait_ready();
        exp_q.push_back(model[5]);
        @(negedge clk);
        req_valid = 1'b0; clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        @(negedge clk);
        check("clr_ign_busy", 32'(busy), 0);
        idle(2);
        check("clr_ign_nq", 32'(busy), 0);

        // clear_start wins over a pending request
        clear_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 9; req_wdata = 8'h55;
        #1 check("clr_pri_ready", 32'(req_ready), 0);
        @(negedge clk);
        check("clr_pri_no_we", 32'(mem_we), 0);
        check("clr_pri_busy",  32'(busy),   1);
        clear_start = 1'b0; req_valid = 1'b0;
        wait_clear();
        rd(7);
        rd(9);

        // Reset during RD_WAIT1 abandons the read and restarts the clear
        wr(3, 8'h77);
        idle(1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3;
        wait_ready();
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1 check("mid_rst_busy",  32'(busy),      1);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_clear();
        rd(3);

        // Instance B: 100-word clear, out-of-range write and read
        check("b_rst_busy", 32'(busy_b), 1);
        rst_n_b = 1'b1;
        bad = 0;
        for (int i = 0; i < DEPTH_B; i++) begin
            @(negedge clk);
            if (!(mem_we_b === 1'b1 && mem_addr_b === AW'(i) && mem_din_b === 8'h00)) bad++;
            if (i < DEPTH_B - 1 && busy_b !== 1'b1) bad++;
        end
        check("b_clear_seq", 32'(bad), 0);
        check("b_clear_busy", 32'(busy_b), 0);

        req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 20; req_wdata_b = 8'h66;
        @(negedge clk);
        check("b_wr_we", 32'(mem_we_b), 1);
        check("b_wr_err", 32'(rsp_err_b), 0);
        req_addr_b = 110; req_wdata_b = 8'h3C;
        @(negedge clk);
        req_valid_b = 1'b0;
        check("b_oor_no_we", 32'(mem_we_b),    0);
        check("b_oor_err",   32'(rsp_err_b),   1);
        check("b_oor_valid", 32'(rsp_valid_b), 0);
        @(negedge clk);
        check("b_oor_err_pulse", 32'(rsp_err_b), 0);
        rd_b(20, 8'h66, 1'b0);
        rd_b(110, 8'h00, 1'b1);
        @(negedge clk);
        check("b_err_pulse_end", 32'(rsp_err_b), 0);

        idle(2);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, data word width; ADDR_WIDTH, default 7, address width; MEM_DEPTH, default 128, number of implemented words (at most 2^ADDR_WIDTH).
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clear_start  in  1  request a full memory clear.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid on a posedge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle read-response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid while rsp_valid is high.
- rsp_err  out  1  one-cycle pulse for an out-of-range access.
- busy  out  1  high in any state other than IDLE.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_din  out  DATA_WIDTH  RAM write data.
- mem_dout  in  DATA_WIDTH  RAM read data; registered in the RAM, one cycle after address.
REQ-003 mem_we, mem_addr, mem_din, rsp_valid, rsp_rdata and rsp_err SHALL be registered outputs; req_ready and busy SHALL be decoded from state.

Function
REQ-004 The block SHALL drive a single-port synchronous RAM that writes on posedge when we=1 and registers data_out from addr on every posedge.
REQ-005 The states SHALL be CLEAR, IDLE, RD_WAIT1 and RD_WAIT2.
REQ-006 CLEAR behaviour:
- On each posedge, load mem_we=1, mem_addr=clear count, mem_din=0, then increment the count.
- Start the count at 0.
- At the edge that loads MEM_DEPTH-1, move to IDLE.
- Result: exactly MEM_DEPTH consecutive write cycles, ascending addresses.
REQ-007 req_ready SHALL be (state==IDLE) && !clear_start.
REQ-008 In IDLE, clear_start=1 SHALL take priority over req_valid: reset the count to 0 and enter CLEAR; no request is accepted in that cycle.
REQ-009 Accepted write at edge N: mem_we=1, mem_addr=req_addr, mem_din=req_wdata during cycle N..N+1; state stays IDLE, so back-to-back writes are accepted every cycle.
REQ-010 Accepted read at edge N:
- mem_we=0 and mem_addr=req_addr are loaded at edge N.
- The FSM passes through RD_WAIT1 (edge N) and RD_WAIT2 (edge N+1).
- At edge N+2, rsp_rdata=mem_dout and rsp_valid=1 for one cycle, and the FSM returns to IDLE.
- Read latency SHALL be 2 cycles from acceptance; req_ready is 0 during both wait states.
REQ-011 In IDLE with no accepted request, mem_we SHALL load 0; mem_addr and mem_din SHALL hold their values.
REQ-012 rsp_rdata SHALL hold its value between responses; rsp_valid and rsp_err SHALL be single-cycle pulses.
REQ-013 A read accepted in the cycle immediately after a write to the same address SHALL return the newly written data.
REQ-014 Out-of-range access (req_addr >= MEM_DEPTH, only possible when MEM_DEPTH < 2^ADDR_WIDTH):
- The request is accepted and mem_we loads 0.
- A write pulses rsp_err one cycle after acceptance.
- A read follows the normal 2-cycle path and returns rsp_rdata=0 with rsp_valid=1 and rsp_err=1 in the same cycle.
REQ-015 clear_start SHALL be ignored in CLEAR, RD_WAIT1 and RD_WAIT2; it is not queued.

Reset
REQ-016 rst_n=0 SHALL asynchronously force:
- state=CLEAR, clear count=0;
- mem_we=0, mem_addr=0, mem_din=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
Decoded outputs during reset: busy=1, req_ready=0.
REQ-017 Reset asserted mid-clear or mid-read SHALL abandon the operation with no response pulse; after release, a full clear SHALL restart from address 0.
REQ-018 busy SHALL fall exactly MEM_DEPTH posedges after rst_n is released.

Verification
REQ-019 Reset release, default parameters: mem_we=1 for 128 cycles with mem_addr 0..127 and mem_din=0; busy falls after edge 128; req_ready rises.
REQ-020 Write 8'hA5 to address 7, then read address 7 on the next cycle: rsp_valid pulses 2 cycles after read acceptance with rsp_rdata=8'hA5; a read of address 8 returns 8'h00.
REQ-021 Back-to-back writes to addresses 0..3 on consecutive cycles: four consecutive mem_we cycles with no stall; reads of 0..3 return the written values, with req_ready low for 2 cycles after each read.
REQ-022 With MEM_DEPTH=100, write to 110 then read 110: no mem_we pulse; rsp_err pulses for each access; the read returns rsp_valid=1, rsp_rdata=0.
REQ-023 clear_start=1 with req_valid=1 in IDLE: req_ready=0, no acceptance, a 100- or 128-cycle clear runs, and a previously written 8'hA5 reads back as 0.
REQ-024 rst_n pulsed low in RD_WAIT1: no rsp_valid; after release the clear restarts at mem_addr=0.
